// File: rtl/pe_ingress_source.sv
`default_nettype none

// ============================================================================
//  Package     : pe_types
//  Description : Shared packet type for the PE mesh port protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_types;
    typedef logic [31:0] packet_t;
endpackage

// ============================================================================
//  Module      : pe_ingress_source
//  Description : Transmit end of a PE mesh ingress port. Packets written by a
//                host/edge agent over a valid/ready interface are buffered in
//                a DEPTH-entry circular FIFO and presented to the mesh as a
//                show-ahead queue (empty / rdata / deq). Tracks occupancy,
//                the number of packets popped, and a sticky error for pops
//                attempted while the queue is empty.
//
//  Ports:
//    clk           in   clock
//    rst           in   asynchronous, active-low reset
//    wr_valid      in   host presents a packet on wr_data
//    wr_ready      out  FIFO accepts a packet this cycle
//    wr_data       in   packet to enqueue
//    flush         in   synchronous clear of all queued packets
//    egress_empty  out  no packet available to the mesh
//    egress_rdata  out  head packet (0 while empty)
//    egress_deq    in   mesh pops the head packet this cycle
//    occupancy     out  entries currently held
//    sent_count    out  packets popped since reset (wraps)
//    deq_err       out  sticky: pop seen while empty
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_ingress_source #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  pe_types::packet_t        wr_data,
    input  logic                     flush,
    output logic                     egress_empty,
    output pe_types::packet_t        egress_rdata,
    input  logic                     egress_deq,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         sent_count,
    output logic                     deq_err
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

    pe_types::packet_t     r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic [c_PTR_W:0]      w_count_next;
    logic [CNT_W-1:0]      r_sent_count;
    logic                  r_deq_err;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_deq_err_set;

    // Full FIFO never accepts, even with a pop in the same cycle: the pop
    // frees its slot only after the edge.
    assign wr_ready      = (r_count < c_DEPTH_CNT) && !flush;
    assign w_empty       = (r_count == '0);
    assign w_push        = wr_valid && wr_ready;
    // Flush wins over pop: a pop in the flush cycle is neither counted nor
    // treated as an error.
    assign w_pop         = egress_deq && !w_empty && !flush;
    assign w_deq_err_set = egress_deq && w_empty && !flush;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer / count state. Pointer widths equal log2(DEPTH), so the
    // increment wraps from DEPTH-1 to 0 on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sent_count <= '0;
            r_deq_err    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sent_count <= r_sent_count + 1'b1;
            end
            if (w_deq_err_set) begin
                r_deq_err <= 1'b1;
            end
        end
    end

    // Storage is not reset; the read mux below masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign egress_empty = w_empty;
    assign egress_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign occupancy    = r_count;
    assign sent_count   = r_sent_count;
    assign deq_err      = r_deq_err;

endmodule

`default_nettype wire

// File: tb/tb_pe_ingress_source.sv
`default_nettype none

// ============================================================================
//  Module      : tb_pe_ingress_source
//  Description : Directed self-checking testbench for pe_ingress_source.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_ingress_source;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                    clk;
    logic                    rst;
    logic                    wr_valid;
    logic                    wr_ready;
    pe_types::packet_t       wr_data;
    logic                    flush;
    logic                    egress_empty;
    pe_types::packet_t       egress_rdata;
    logic                    egress_deq;
    logic [$clog2(DEPTH):0]  occupancy;
    logic [CNT_W-1:0]        sent_count;
    logic                    deq_err;

    int total;
    int bad;

    pe_ingress_source #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .flush        (flush),
        .egress_empty (egress_empty),
        .egress_rdata (egress_rdata),
        .egress_deq   (egress_deq),
        .occupancy    (occupancy),
        .sent_count   (sent_count),
        .deq_err      (deq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set afterwards apply to the
    // following edge and outputs are sampled here, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid   = 1'b0;
        wr_data    = '0;
        flush      = 1'b0;
        egress_deq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        step();
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", egress_empty); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_sent_count got=%0d want=0", sent_count); end
        total++; if (deq_err !== 1'b0) begin bad++; $display("FAIL reset_deq_err got=%b want=0", deq_err); end
        total++; if (egress_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", egress_rdata); end

        // Load one packet, then pulse reset between edges.
        wr_valid = 1'b1;
        wr_data  = 32'h77;
        step();
        wr_valid = 1'b0;
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL prereset_occupancy got=%0d want=1", occupancy); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL async_reset_empty got=%b want=1", egress_empty); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL async_reset_occupancy got=%0d want=0", occupancy); end
        total++; if (egress_rdata !== 32'h0) begin bad++; $display("FAIL async_reset_rdata got=%h want=0", egress_rdata); end
        step();
        rst = 1'b1;
        step();
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL post_reset_empty got=%b want=1", egress_empty); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_data;
        wr_valid = 1'b1;
        wr_data  = 32'hA1;
        step();
        total++; if (egress_empty !== 1'b0) begin bad++; $display("FAIL basic_first_visible got=%b want=0", egress_empty); end
        total++; if (egress_rdata !== 32'hA1) begin bad++; $display("FAIL basic_first_rdata got=%h want=a1", egress_rdata); end
        wr_data = 32'hA2;
        step();
        wr_data = 32'hA3;
        step();
        wr_valid = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL basic_occupancy got=%0d want=3", occupancy); end
        egress_deq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_data = 32'hA1 + i;
            total++; if (egress_rdata !== exp_data) begin bad++; $display("FAIL basic_pop%0d got=%h want=%h", i, egress_rdata, exp_data); end
            step();
        end
        egress_deq = 1'b0;
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL basic_drained got=%b want=1", egress_empty); end
        total++; if (sent_count !== 16'd3) begin bad++; $display("FAIL basic_sent got=%0d want=3", sent_count); end
        total++; if (egress_rdata !== 32'h0) begin bad++; $display("FAIL basic_empty_rdata got=%h want=0", egress_rdata); end
    endtask

    task automatic test_full();
        logic [31:0] exp_data;
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 32'h10 + i;
            step();
        end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b want=0", wr_ready); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occupancy got=%0d want=4", occupancy); end
        // Fifth write with a pop in the same cycle must still be held off.
        wr_data    = 32'h14;
        egress_deq = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%b want=0", wr_ready); end
        total++; if (egress_rdata !== 32'h10) begin bad++; $display("FAIL full_head got=%h want=10", egress_rdata); end
        step();
        egress_deq = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL full_after_pop_occ got=%0d want=3", occupancy); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop_ready got=%b want=1", wr_ready); end
        step();
        wr_valid = 1'b0;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_refill_occ got=%0d want=4", occupancy); end
        egress_deq = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_data = 32'h11 + i;
            total++; if (egress_rdata !== exp_data) begin bad++; $display("FAIL full_order%0d got=%h want=%h", i, egress_rdata, exp_data); end
            step();
        end
        egress_deq = 1'b0;
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b want=1", egress_empty); end
        total++; if (sent_count !== 16'd8) begin bad++; $display("FAIL full_sent got=%0d want=8", sent_count); end
        total++; if (deq_err !== 1'b0) begin bad++; $display("FAIL full_no_err got=%b want=0", deq_err); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_data;
        wr_valid = 1'b1;
        wr_data  = 32'h200;
        step();
        egress_deq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data  = 32'h201 + i;
            exp_data = 32'h200 + i;
            total++; if (egress_rdata !== exp_data) begin bad++; $display("FAIL stream_data%0d got=%h want=%h", i, egress_rdata, exp_data); end
            step();
            total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL stream_occ%0d got=%0d want=1", i, occupancy); end
        end
        idle_inputs();
        total++; if (sent_count !== 16'd28) begin bad++; $display("FAIL stream_sent got=%0d want=28", sent_count); end
        total++; if (egress_rdata !== 32'h214) begin bad++; $display("FAIL stream_tail got=%h want=214", egress_rdata); end
        egress_deq = 1'b1;
        step();
        egress_deq = 1'b0;
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL stream_drained got=%b want=1", egress_empty); end
    endtask

    task automatic test_deq_empty();
        egress_deq = 1'b1;
        step();
        egress_deq = 1'b0;
        total++; if (deq_err !== 1'b1) begin bad++; $display("FAIL deq_empty_err got=%b want=1", deq_err); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL deq_empty_occ got=%0d want=0", occupancy); end
        total++; if (sent_count !== 16'd29) begin bad++; $display("FAIL deq_empty_sent got=%0d want=29", sent_count); end
        wr_valid = 1'b1;
        wr_data  = 32'h30;
        step();
        wr_valid = 1'b0;
        total++; if (egress_rdata !== 32'h30) begin bad++; $display("FAIL deq_empty_next got=%h want=30", egress_rdata); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL deq_empty_next_occ got=%0d want=1", occupancy); end
        egress_deq = 1'b1;
        step();
        egress_deq = 1'b0;
        total++; if (deq_err !== 1'b1) begin bad++; $display("FAIL deq_err_sticky got=%b want=1", deq_err); end
        total++; if (sent_count !== 16'd30) begin bad++; $display("FAIL deq_empty_sent2 got=%0d want=30", sent_count); end
    endtask

    task automatic test_flush();
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'h41 + i;
            step();
        end
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d want=3", occupancy); end
        wr_data    = 32'h55;
        flush      = 1'b1;
        egress_deq = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL flush_wr_ready got=%b want=0", wr_ready); end
        step();
        idle_inputs();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", egress_empty); end
        total++; if (sent_count !== 16'd30) begin bad++; $display("FAIL flush_sent got=%0d want=30", sent_count); end
        total++; if (egress_rdata !== 32'h0) begin bad++; $display("FAIL flush_rdata got=%h want=0", egress_rdata); end
        wr_valid = 1'b1;
        wr_data  = 32'h66;
        step();
        wr_valid = 1'b0;
        total++; if (egress_rdata !== 32'h66) begin bad++; $display("FAIL flush_next got=%h want=66", egress_rdata); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL flush_next_occ got=%0d want=1", occupancy); end
        egress_deq = 1'b1;
        step();
        egress_deq = 1'b0;
        total++; if (egress_empty !== 1'b1) begin bad++; $display("FAIL flush_final_empty got=%b want=1", egress_empty); end
        total++; if (sent_count !== 16'd31) begin bad++; $display("FAIL flush_final_sent got=%0d want=31", sent_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_full();
        test_streaming();
        test_deq_empty();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pe_ingress_source.md
Name: pe_ingress_source

Overview:
- Transmit end of the PE mesh port protocol. Drives one cluster ingress port: `empty`, `rdata`, `deq` (a show-ahead queue that the PE pops).
- Accepts packets from a host/edge agent over a valid/ready write interface and buffers them in a DEPTH-entry FIFO.
- Exposes them to the mesh with show-ahead semantics.
- Tracks occupancy, sent count and protocol errors.
- Instantiated once per mesh-edge ingress port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- wr_valid  input  1  host has a packet on `wr_data`.
- wr_ready  output  1  FIFO can accept this cycle.
- wr_data  input  packet_t  packet to enqueue (pe_types::packet_t).
- flush  input  1  synchronous clear of all queued packets.
- egress_empty  output  1  no packet available to the mesh.
- egress_rdata  output  packet_t  head packet; valid while `egress_empty`=0.
- egress_deq  input  1  mesh pops the head packet this cycle.
- occupancy  output  $clog2(DEPTH)+1  entries currently held.
- sent_count  output  CNT_W  packets popped since reset; wraps.
- deq_err  output  1  sticky: `egress_deq` seen while `egress_empty`=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count are cleared.
  - `egress_empty`=1, `wr_ready`=1, `occupancy`=0, `sent_count`=0, `deq_err`=0.
  - `egress_rdata`=0.
  - Reset asserted mid-transfer discards all held packets; no partial state survives.
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits plus a count register. Pointers wrap from DEPTH-1 to 0.
- Write handshake:
  - Enqueue occurs when `wr_valid` && `wr_ready` at a rising clk edge.
  - `wr_ready` = (count < DEPTH) && !flush. It is combinational from registered state and `flush`.
  - When full, `wr_ready`=0 even if `egress_deq` is asserted that cycle. There is no same-cycle bypass of a full FIFO.
- Read side (show-ahead):
  - `egress_empty` = (count == 0), registered state only.
  - `egress_rdata` = mem[rd_ptr], held stable while empty=0 and no deq occurs.
  - Pop occurs when `egress_deq` && !`egress_empty`: rd_ptr advances and `sent_count` increments modulo 2^CNT_W.
  - `egress_deq` while empty: ignored (no pointer or count change) and sets `deq_err`. `deq_err` clears only on reset.
- Latency: a packet written into an empty FIFO at edge N appears with `egress_empty`=0 after edge N (visible in cycle N+1). There is no combinational write-to-read path.
- Simultaneous write and pop (0 < count < DEPTH): both take effect; count is unchanged; FIFO order is preserved.
- Write and pop at count==0: only the write is legal, because the mesh sees empty=1. Any deq that cycle is an error per the rule above.
- Flush (priority over write and pop in the same cycle):
  - At the edge: pointers and count are set to 0 and nothing is enqueued.
  - `egress_empty`=1 from the next cycle.
  - A pop asserted in the flush cycle is not counted and is not an error.
  - `sent_count` and `deq_err` are not cleared.
- Count update: count_next = count + push - pop, where push and pop are the qualified handshakes. Count never exceeds DEPTH or underflows.
- `occupancy` = count, registered.
- `mem` is not reset; `egress_rdata` is forced to 0 while empty, so no X reaches the mesh.

Test Plan:
- Reset then idle:
  - Expect empty=1, wr_ready=1, occupancy=0, sent_count=0, deq_err=0, rdata=0.
  - Pulse rst low asynchronously between edges; outputs clear immediately.
- Write 0xA1, 0xA2, 0xA3 on consecutive cycles with no deq:
  - empty falls the cycle after the first write; rdata=0xA1; occupancy=3.
  - Then deq for 3 cycles: rdata shows 0xA1, 0xA2, 0xA3 in turn; empty=1 after the third pop; sent_count=3.
- Fill to DEPTH=4 with 0x10..0x13:
  - wr_ready=0; a fifth write of 0x14 is held off even with deq high that cycle.
  - After the pop, 0x14 is accepted next cycle; the mesh receives 0x10..0x14 in order; pointers wrap correctly.
- Steady streaming, wr_valid and deq high every cycle from occupancy=1, for 20 cycles:
  - occupancy stays 1; sent_count=20; no drops or duplicates.
- deq while empty: deq_err=1 and remains 1 through later traffic; count, pointers and sent_count are unchanged.
- With occupancy=3, assert flush together with wr_valid (0x55) and deq:
  - Next cycle occupancy=0, empty=1, sent_count unchanged, 0x55 not stored.
  - A subsequent write of 0x66 emerges first.
